// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial pattern detector: FSM state encoding and
// the legal range of the pattern length.
package seq_detect_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_FILL = 2'b01;
   localparam logic [1:0] ST_SCAN = 2'b10;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   assign sat = &count;

   // Count register: clear first, then increment only below saturation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: runtime-loaded pattern, overlapping or
// non-overlapping matching, registered match pulse and saturating count.
module seq_detect_fsm
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_in,
   input  logic             x_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap_in,
   input  logic             cnt_clr,
   output logic             y_out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat,
   output logic [1:0]       state
);

   localparam int              FC_W      = $clog2(PAT_W + 1);
   localparam logic [FC_W-1:0] FILL_LAST = FC_W'(PAT_W - 1);
   localparam logic [FC_W-1:0] FILL_FULL = FC_W'(PAT_W);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detect_fsm: PAT_W out of legal range");
   end

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_nxt;
   logic [PAT_W-1:0] pat_reg;
   logic [PAT_W-1:0] pat_nxt;
   logic [PAT_W-1:0] window;
   logic [FC_W-1:0]  fill_cnt;
   logic [FC_W-1:0]  fill_nxt;
   logic [1:0]       state_nxt;
   logic             ovl_reg;
   logic             ovl_nxt;
   logic             y_nxt;
   logic             hit;
   logic             inc;

   assign window = {hist[PAT_W-2:0], x_in};
   assign hit    = (window == pat_reg);

   // Next-state logic; cfg_load overrides everything, including a valid bit
   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill_cnt;
      pat_nxt   = pat_reg;
      ovl_nxt   = ovl_reg;
      y_nxt     = 1'b0;
      inc       = 1'b0;
      if (cfg_load) begin
         state_nxt = ST_FILL;
         hist_nxt  = '0;
         fill_nxt  = '0;
         pat_nxt   = pat_in;
         ovl_nxt   = overlap_in;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_FILL, ST_SCAN: begin
               if (x_valid) begin
                  hist_nxt = window;
                  if (state == ST_FILL && fill_cnt != FILL_LAST) begin
                     fill_nxt = fill_cnt + FC_W'(1);
                  end else if (hit && !ovl_reg) begin
                     // Non-overlapping: demand PAT_W fresh bits before the next match
                     state_nxt = ST_FILL;
                     fill_nxt  = '0;
                     y_nxt     = 1'b1;
                     inc       = 1'b1;
                  end else begin
                     state_nxt = ST_SCAN;
                     fill_nxt  = FILL_FULL;
                     y_nxt     = hit;
                     inc       = hit;
                  end
               end else begin
                  state_nxt = state;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, history, configuration and match pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         hist     <= '0;
         fill_cnt <= '0;
         pat_reg  <= '0;
         ovl_reg  <= 1'b0;
         y_out    <= 1'b0;
      end else begin
         state    <= state_nxt;
         hist     <= hist_nxt;
         fill_cnt <= fill_nxt;
         pat_reg  <= pat_nxt;
         ovl_reg  <= ovl_nxt;
         y_out    <= y_nxt;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .clr   (cnt_clr),
      .count (match_cnt),
      .sat   (cnt_sat)
   );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: two instances (4-bit/8-bit count, 2-bit/2-bit count)
// checked every cycle against a window-based model plus directed literals.
module tb_seq_detect_fsm;

   logic       clk;
   logic       rst;
   logic       x_in;
   logic       x_valid;
   logic       cfg_load;
   logic       overlap_in;
   logic       cnt_clr;
   logic [3:0] pat_a;
   logic [1:0] pat_b;
   logic       y_a;
   logic       y_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic       sat_a;
   logic       sat_b;
   logic [1:0] state_a;
   logic [1:0] state_b;

   int checks   = 0;
   int failures = 0;

   seq_detect_fsm #(.PAT_W(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .cfg_load(cfg_load),
      .pat_in(pat_a), .overlap_in(overlap_in), .cnt_clr(cnt_clr),
      .y_out(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .state(state_a)
   );

   seq_detect_fsm #(.PAT_W(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .cfg_load(cfg_load),
      .pat_in(pat_b), .overlap_in(overlap_in), .cnt_clr(cnt_clr),
      .y_out(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .state(state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: configured flag, count of fresh bits (capped at PW) and bit window
   bit          cfgd [2];
   int          nbits[2];
   logic [31:0] win  [2];
   logic [31:0] mpat [2];
   bit          movl [2];
   int          mcnt [2];
   bit          my   [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input int i, input int pw, input int cmax);
      logic [31:0] mask;
      bit          hit;
      mask = (32'd1 << pw) - 32'd1;
      hit  = 1'b0;
      if (rst) begin
         cfgd[i] = 1'b0; nbits[i] = 0; win[i] = 32'd0; mpat[i] = 32'd0;
         movl[i] = 1'b0; mcnt[i] = 0; my[i] = 1'b0;
      end else begin
         if (cfg_load) begin
            cfgd[i]  = 1'b1;
            nbits[i] = 0;
            win[i]   = 32'd0;
            mpat[i]  = (i == 0) ? {28'd0, pat_a} : {30'd0, pat_b};
            movl[i]  = overlap_in;
         end else if (cfgd[i] && x_valid) begin
            win[i] = (win[i] << 1) | {31'd0, x_in};
            if (nbits[i] < pw) nbits[i]++;
            if (nbits[i] == pw && (win[i] & mask) == mpat[i]) begin
               hit = 1'b1;
               if (!movl[i]) nbits[i] = 0;
            end
         end
         my[i] = hit;
         if (cnt_clr) mcnt[i] = 0;
         else if (hit && mcnt[i] < cmax) mcnt[i]++;
      end
   endtask

   function automatic int exp_state(input int i, input int pw);
      if (!cfgd[i]) return 0;
      else if (nbits[i] < pw) return 1;
      else return 2;
   endfunction

   // Per-cycle compare of both instances against the model
   always @(posedge clk) begin
      model_edge(0, 4, 255);
      model_edge(1, 2, 3);
      #2;
      chk("a_y",     {31'd0, y_a},     {31'd0, my[0]});
      chk("a_cnt",   {24'd0, cnt_a},   mcnt[0]);
      chk("a_sat",   {31'd0, sat_a},   (mcnt[0] == 255) ? 32'd1 : 32'd0);
      chk("a_state", {30'd0, state_a}, exp_state(0, 4));
      chk("b_y",     {31'd0, y_b},     {31'd0, my[1]});
      chk("b_cnt",   {30'd0, cnt_b},   mcnt[1]);
      chk("b_sat",   {31'd0, sat_b},   (mcnt[1] == 3) ? 32'd1 : 32'd0);
      chk("b_state", {30'd0, state_b}, exp_state(1, 2));
   end

   task automatic cyc(input logic v, input logic b, input logic ld, input logic clr);
      @(negedge clk);
      x_valid = v; x_in = b; cfg_load = ld; cnt_clr = clr;
   endtask

   // Drive one valid bit and check the match pulse of instance d one edge later
   task automatic send_chk(input string name, input int d, input logic b,
                           input logic clr, input logic exp_y);
      cyc(1'b1, b, 1'b0, clr);
      @(posedge clk);
      #2;
      chk(name, (d == 0) ? {31'd0, y_a} : {31'd0, y_b}, {31'd0, exp_y});
   endtask

   logic [6:0] s_1011;
   logic [6:0] e_ovl;
   logic [6:0] e_novl;
   logic [5:0] e_ones;

   initial begin
      rst = 1'b1; x_in = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      overlap_in = 1'b0; pat_a = 4'b0000; pat_b = 2'b01;
      s_1011 = 7'b1011011;   // bits sent MSB first: 1,0,1,1,0,1,1
      e_ovl  = 7'b0001001;
      e_novl = 7'b0001000;
      e_ones = 6'b000111;

      // Reset with x_valid toggling
      for (int k = 0; k < 4; k++) cyc(k[0], 1'b1, 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("rst_state", {30'd0, state_a}, 32'd0);
      chk("rst_y",     {31'd0, y_a},     32'd0);
      chk("rst_cnt",   {24'd0, cnt_a},   32'd0);
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #2;
      chk("idle_no_cfg", {30'd0, state_a}, 32'd0);

      // Pattern 1011, overlapping
      @(negedge clk); pat_a = 4'b1011; overlap_in = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 6; k >= 0; k--) send_chk("ovl_1011_y", 0, s_1011[k], 1'b0, e_ovl[k]);
      chk("ovl_1011_cnt", {24'd0, cnt_a}, 32'd2);

      // Same stream, non-overlapping
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #2;
      chk("clr_cnt", {24'd0, cnt_a}, 32'd0);
      @(negedge clk); overlap_in = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 6; k >= 0; k--) begin
         send_chk("novl_1011_y", 0, s_1011[k], 1'b0, e_novl[k]);
         if (k == 3) chk("novl_state_fill", {30'd0, state_a}, 32'd1);
      end
      chk("novl_1011_cnt", {24'd0, cnt_a}, 32'd1);

      // Pattern 1111, overlapping, cnt_clr with the bit-6 match
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); pat_a = 4'b1111; overlap_in = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 5; k >= 0; k--) begin
         send_chk("ones_y", 0, 1'b1, (k == 0), e_ones[k]);
         if (k == 1) chk("ones_cnt_pre", {24'd0, cnt_a}, 32'd2);
      end
      chk("ones_clr_cnt", {24'd0, cnt_a}, 32'd0);

      // Two-bit pattern 01 on the small instance: counter saturates
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         send_chk("b01_y0", 1, 1'b0, 1'b0, 1'b0);
         send_chk("b01_y1", 1, 1'b1, 1'b0, 1'b1);
      end
      chk("b_sat_cnt", {30'd0, cnt_b}, 32'd3);
      chk("b_sat_flag", {31'd0, sat_b}, 32'd1);

      // Reload mid-FILL with a valid bit that must be discarded
      @(negedge clk); pat_a = 4'b1011; overlap_in = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      send_chk("pre_reload_y", 0, 1'b1, 1'b0, 1'b0);
      send_chk("pre_reload_y", 0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #2;
      chk("reload_state", {30'd0, state_a}, 32'd1);
      send_chk("reload_y", 0, 1'b1, 1'b0, 1'b0);
      send_chk("reload_y", 0, 1'b0, 1'b0, 1'b0);
      send_chk("reload_y", 0, 1'b1, 1'b0, 1'b0);
      chk("reload_fill3", {30'd0, state_a}, 32'd1);
      send_chk("reload_match", 0, 1'b1, 1'b0, 1'b1);
      chk("scan_state", {30'd0, state_a}, 32'd2);

      // Asynchronous reset mid-SCAN
      #3; rst = 1'b1;
      #1;
      chk("arst_state", {30'd0, state_a}, 32'd0);
      chk("arst_y",     {31'd0, y_a},     32'd0);
      chk("arst_cnt",   {24'd0, cnt_a},   32'd0);
      chk("arst_cnt_b", {30'd0, cnt_b},   32'd0);
      chk("arst_sat_b", {31'd0, sat_b},   32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #3;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
